// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC and keeps at most one request in flight to
// instruction memory. It feeds the IF/ID register and handles stalls and redirects.
// Optional build macro FETCH_PERF_EN adds the fetch_count and flush_count counters.
//
// state | meaning
// REQ   | present pc on the request channel, wait for acceptance
// WAIT  | request in flight, wait for its response
// DROP  | in-flight request was flushed, swallow its response
// HOLD  | response arrived under stall, buffered in hold_instr
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        valid_out
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;

    logic        deliver;
    logic [31:0] deliver_data;
    logic [31:0] redir_pc;

    // Redirect targets are always word aligned; the low two bits are dropped.
    assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

    // Request channel is combinational so a redirect suppresses the request in the same cycle.
    always_comb begin
        imem_req_valid = (state_q == S_REQ) && !redirect_valid;
        imem_req_addr  = pc_q;
    end

    // Fetch sequencing: next state, pc, outstanding address and the stall buffer.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_pc_d   = fetch_pc_q;
        hold_instr_d = hold_instr_q;
        deliver      = 1'b0;
        deliver_data = imem_rsp_data;
        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                end else if (imem_req_ready) begin
                    fetch_pc_d = pc_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = imem_rsp_valid ? S_REQ : S_DROP;
                end else if (imem_rsp_valid) begin
                    if (!stall) begin
                        deliver = 1'b1;
                        pc_d    = fetch_pc_q + 32'd4;
                        state_d = S_REQ;
                    end else begin
                        hold_instr_d = imem_rsp_data;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                end
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = S_REQ;
                end else if (!stall) begin
                    deliver      = 1'b1;
                    deliver_data = hold_instr_q;
                    pc_d         = fetch_pc_q + 32'd4;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // IF/ID output register: redirect flushes, stall freezes, otherwise bubble or deliver.
    always_comb begin
        valid_d  = 1'b0;
        instr_d  = NOP_INSTR;
        pc_out_d = pc_out_q;
        if (redirect_valid) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (stall) begin
            valid_d = valid_q;
            instr_d = instr_q;
        end else if (deliver) begin
            valid_d  = 1'b1;
            instr_d  = deliver_data;
            pc_out_d = fetch_pc_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            fetch_pc_q   <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc_out_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_pc_q   <= fetch_pc_d;
            hold_instr_q <= hold_instr_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
        end
    end

    assign valid_out       = valid_q;
    assign instruction_out = instr_q;
    assign pc_out          = pc_out_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Performance counters: deliveries and redirect cycles, both wrapping.
    always_comb begin
        fetch_count_d = fetch_count_q + {31'd0, deliver};
        flush_count_d = flush_count_q + {31'd0, redirect_valid};
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count_q <= 32'd0;
            flush_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule
